slave_control: RTL and testbench

SLAVE_CONTROL -- requirements
Module: slave_control

---
 rtl/c2c_pkg.sv | 8 +
 rtl/c2c_timer.sv | 20 ++
 rtl/slave_control.sv | 90 +++++++++
 tb/tb_slave_control.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/c2c_pkg.sv
// c2c_pkg: state encodings, bus width and timer sizing shared by the c2c link endpoints.
package c2c_pkg;
  localparam int C2C_DATA_W = 3;
  typedef enum logic [1:0] {S_WAIT_RQST, S_NOTICE, S_WAIT_VALID, S_WAIT_DROP} c2c_state_e;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/c2c_timer.sv
// c2c_timer: interval counter, cleared by clr, raising done once lim cycles have elapsed and holding there.
module c2c_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [CW-1:0] lim,
  output logic          done
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    done  = cnt_q == lim - CW'(1);
    cnt_d = clr ? '0 : cnt_q + CW'(!done);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/slave_control.sv
// slave_control: receiving end of the request/notice/ack/valid handshake with registered outputs.
// Define SLAVE_TIMEOUT_EN to abort a wait for valid after TIMEOUT_CYCLES and raise a sticky timeout.
module slave_control
  import c2c_pkg::*;
#(
  parameter int DATA_W         = C2C_DATA_W,
  parameter int ONE_SEC_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES = 200_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              request,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack,
  output logic              notice,
  output logic [DATA_W-1:0] data_out,
  output logic              data_strobe,
  output logic              timeout
);
  localparam int CW = cnt_w(ONE_SEC_CYCLES, TIMEOUT_CYCLES);
  c2c_state_e state_q, state_d;
  logic [1:0] req_sync_q, req_sync_d, val_sync_q, val_sync_d;
  logic ack_q, ack_d, notice_q, notice_d, strobe_q, strobe_d, timeout_q, timeout_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic req_s, val_s, cap, expire, done;
  logic [CW-1:0] lim;
  c2c_timer #(.CW(CW)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_d != state_q),
    .lim  (lim),
    .done (done)
  );
  always_comb begin
    req_sync_d = {req_sync_q[0], request};
    val_sync_d = {val_sync_q[0], valid};
    req_s      = req_sync_q[1];
    val_s      = val_sync_q[1];
    // capture only once ack is actually visible to the master
    cap        = state_q == S_WAIT_VALID && ack_q && val_s;
`ifdef SLAVE_TIMEOUT_EN
    expire     = state_q == S_WAIT_VALID && done && !cap;
    lim        = state_q == S_NOTICE ? CW'(ONE_SEC_CYCLES) : CW'(TIMEOUT_CYCLES);
    timeout_d  = !cap && (expire || timeout_q);
`else
    expire     = 1'b0;
    lim        = CW'(ONE_SEC_CYCLES);
    timeout_d  = 1'b0;
`endif
    state_d = state_q;
    unique case (state_q)
      S_WAIT_RQST:  if (req_s) state_d = S_NOTICE;
      S_NOTICE:     if (done) state_d = S_WAIT_VALID;
      S_WAIT_VALID: if (cap || expire) state_d = S_WAIT_DROP;
      S_WAIT_DROP:  if (!val_s && !req_s) state_d = S_WAIT_RQST;
    endcase
    notice_d = state_d == S_NOTICE;
    // ack waits one cycle in S_WAIT_VALID so it trails the falling notice
    ack_d    = state_q == S_WAIT_VALID && state_d == S_WAIT_VALID;
    strobe_d = cap;
    data_d   = cap ? data_in : data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_WAIT_RQST;
      req_sync_q <= '0;
      val_sync_q <= '0;
      ack_q      <= 1'b0;
      notice_q   <= 1'b0;
      strobe_q   <= 1'b0;
      timeout_q  <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_sync_q <= req_sync_d;
      val_sync_q <= val_sync_d;
      ack_q      <= ack_d;
      notice_q   <= notice_d;
      strobe_q   <= strobe_d;
      timeout_q  <= timeout_d;
      data_q     <= data_d;
    end
  end
  assign ack         = ack_q;
  assign notice      = notice_q;
  assign data_out    = data_q;
  assign data_strobe = strobe_q;
  assign timeout     = timeout_q;
endmodule

// File: tb/tb_slave_control.sv
// tb_slave_control: directed handshake sequences checked every cycle against a procedural protocol model.
module tb_slave_control;
  localparam int ONE = 8;
  localparam int TO  = 20;
`ifdef SLAVE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, request = 0, valid = 0;
  logic [2:0] data_in = 3'b000, data_out;
  logic ack, notice, data_strobe, timeout;
  int total = 0, bad = 0, strobes = 0;
  bit e_notice = 0, e_ack = 0, e_strobe = 0, e_to = 0, rs = 0, vs = 0, ab = 0, fin = 0;
  logic [2:0] e_data = 3'b000, dsamp = 3'b000;
  logic [1:0] sr = 2'b00, sv = 2'b00;

  slave_control #(.DATA_W(3), .ONE_SEC_CYCLES(ONE), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .request    (request),
    .valid      (valid),
    .data_in    (data_in),
    .ack        (ack),
    .notice     (notice),
    .data_out   (data_out),
    .data_strobe(data_strobe),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // one clock of the model: synchronized values seen by the decision at this edge
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      ab = 1; sr = 0; sv = 0; rs = 0; vs = 0;
      e_notice = 0; e_ack = 0; e_strobe = 0; e_to = 0; e_data = 0;
    end else begin
      rs = sr[1]; vs = sv[1]; dsamp = data_in;
      sr = {sr[0], request};
      sv = {sv[0], valid};
    end
  endtask

  initial begin
    forever begin
      ab = 0; e_notice = 0; e_ack = 0; e_strobe = 0;
      do step(); while (!ab && !rs);
      if (!ab) e_notice = 1;
      for (int i = 0; i < ONE && !ab; i++) step();
      if (!ab) e_notice = 0;
      fin = ab;
      for (int k = 1; !fin; k++) begin
        step();
        fin = 1;
        if (!ab && k >= 2 && vs) begin
          e_ack = 0; e_strobe = 1; e_data = dsamp; e_to = 0;
        end else if (!ab && TO_EN && k == TO) begin
          e_ack = 0; e_to = 1;
        end else if (!ab) begin
          e_ack = 1; fin = 0;
        end
      end
      while (!ab) begin
        step();
        e_strobe = 0;
        if (!rs && !vs) break;
      end
    end
  end

  always @(negedge clk) begin
    chk("ack", ack, rst_n ? e_ack : 0);
    chk("notice", notice, rst_n ? e_notice : 0);
    chk("data_strobe", data_strobe, rst_n ? e_strobe : 0);
    chk("data_out", data_out, rst_n ? e_data : 0);
    chk("timeout", timeout, rst_n ? e_to : 0);
    if (data_strobe) strobes++;
  end

  task automatic xfer(input logic [2:0] d, input logic [2:0] prev, input bit glitch, input bit early, input int hold);
    int n, s0;
    s0 = strobes;
    request = 1;
    if (glitch) begin @(negedge clk); request = 0; end
    n = 0;
    while (!notice && n < 12) begin @(negedge clk); n++; end
    chk("notice_rise", notice, 1);
    n = 0;
    if (early) begin
      valid = 1; data_in = 3'b010;
      repeat (3) @(negedge clk);
      valid = 0; n = 3;
    end
    while (notice && n < 20) begin @(negedge clk); n++; end
    chk("notice_len", n, ONE);
    chk("ack_gap", ack, 0);
    @(negedge clk);
    chk("ack_rise", ack, 1);
    chk("no_early_strobe", strobes, s0);
    chk("data_held", data_out, prev);
    valid = 1; data_in = d;
    n = 0;
    while (!data_strobe && n < 8) begin @(negedge clk); n++; end
    chk("strobe_seen", data_strobe, 1);
    chk("capture", data_out, d);
    chk("ack_drop", ack, 0);
    @(negedge clk);
    chk("strobe_1cyc", data_strobe, 0);
    valid = 0; data_in = 3'b000;
    repeat (hold) begin @(negedge clk); chk("hold_idle", notice | ack, 0); end
    request = 0;
    repeat (4) @(negedge clk);
    chk("idle_after", notice | ack, 0);
    chk("one_strobe", strobes, s0 + 1);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_notice", notice, 0);
    chk("rst_data", data_out, 0);
    #2 rst_n = 1;
    repeat (3) @(negedge clk);
    xfer(3'b101, 3'b000, 0, 0, 0);
    xfer(3'b110, 3'b101, 1, 0, 0);
    xfer(3'b011, 3'b110, 0, 1, 0);
    xfer(3'b010, 3'b011, 0, 0, 10);
    xfer(3'b100, 3'b010, 0, 0, 0);
    request = 1;
    n = 0;
    while (!ack && n < 30) begin @(negedge clk); n++; end
    chk("pre_reset_ack", ack, 1);
    #2 rst_n = 0;
    #1 chk("reset_ack_now", ack, 0);
    chk("reset_notice_now", notice, 0);
    chk("reset_data_now", data_out, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1; request = 0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", notice | ack, 0);
    xfer(3'b111, 3'b000, 0, 0, 0);
    request = 1;
    n = 0;
    while (!ack && n < 30) begin @(negedge clk); n++; end
    chk("to_ack_up", ack, 1);
    request = 0;
    repeat (22) @(negedge clk);
    chk("to_flag", timeout, TO_EN);
    chk("to_ack", ack, !TO_EN);
    if (!TO_EN) begin
      valid = 1; data_in = 3'b100;
      repeat (4) @(negedge clk);
      valid = 0; data_in = 3'b000;
    end
    repeat (4) @(negedge clk);
    xfer(3'b001, TO_EN ? 3'b111 : 3'b100, 0, 0, 0);
    chk("to_cleared", timeout, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
